// File: rtl/program_loader.sv
// program_loader
//   Loads a 16-word program image from a slow asynchronous serial source into
//   program memory while holding the CPU stalled. A session is 16 data bytes
//   (MSB first), each written as one memory word, followed by one
//   two's-complement checksum byte. The session succeeds when the 8-bit sum of
//   all 17 bytes is zero.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   load_req       level request to run a session (synchronous to clk)
//   ser_clk        asynchronous serial bit clock, data sampled on its rise
//   ser_data       asynchronous serial data, MSB first
//   mem_address    program memory write address
//   mem_immediate  write data, byte bits [7:4]
//   mem_opcode     write data, byte bits [3:0]
//   mem_write      one-cycle write strobe
//   cpu_hold       CPU stall / address-mux select
//   busy           session in progress
//   done           last session completed with a good checksum (sticky)
//   error          last session failed or was aborted (sticky)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for load_req; serial activity ignored
// SHIFT | collecting the 8 bits of the current byte
// WRITE | one-cycle memory write of the completed byte
// CHECK | one-cycle checksum evaluation after the 17th byte
// DONE  | good image loaded; waits for load_req to drop
// ERROR | bad checksum; CPU kept stalled until load_req drops
//
// SYNC_STAGES must be at least 2: the sample edge is detected between the
// last two synchronizer stages.

module program_loader #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_req,
  input  logic       ser_clk,
  input  logic       ser_data,
  output logic [3:0] mem_address,
  output logic [3:0] mem_immediate,
  output logic [3:0] mem_opcode,
  output logic       mem_write,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  state_t state;

  // Bit 0 is the newest synchronizer stage, bit SYNC_STAGES-1 the oldest.
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;

  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic [4:0] word_cnt;
  logic [7:0] checksum;

  logic       sample_evt;
  logic       sample_bit;
  logic [7:0] shift_nxt;
  logic [7:0] checksum_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '0;
      data_sync <= '0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ser_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ser_data};
    end
  end

  // Rising ser_clk seen between the last two stages; the data bit is taken
  // from the stage aligned with the newer clock stage.
  assign sample_evt   = clk_sync[SYNC_STAGES-2] & ~clk_sync[SYNC_STAGES-1];
  assign sample_bit   = data_sync[SYNC_STAGES-2];
  assign shift_nxt    = {shift[6:0], sample_bit};
  assign checksum_sum = checksum + shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      shift         <= '0;
      bit_cnt       <= '0;
      word_cnt      <= '0;
      checksum      <= '0;
      mem_address   <= '0;
      mem_immediate <= '0;
      mem_opcode    <= '0;
      mem_write     <= 1'b0;
      cpu_hold      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_write <= 1'b0;
          if (load_req) begin
            state    <= SHIFT;
            shift    <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            checksum <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            busy     <= 1'b1;
            cpu_hold <= 1'b1;
          end
        end

        SHIFT: begin
          if (!load_req) begin
            // Abort wins over a byte completing in the same cycle.
            state    <= IDLE;
            error    <= 1'b1;
            done     <= 1'b0;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
          end else if (sample_evt) begin
            shift <= shift_nxt;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              if (word_cnt < 5'd16) begin
                // Outputs are registered, so the write word is taken from the
                // byte being completed rather than the shift register.
                state         <= WRITE;
                mem_write     <= 1'b1;
                mem_address   <= word_cnt[3:0];
                mem_immediate <= shift_nxt[7:4];
                mem_opcode    <= shift_nxt[3:0];
              end else begin
                state <= CHECK;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end

        WRITE: begin
          mem_write <= 1'b0;
          if (!load_req) begin
            state    <= IDLE;
            error    <= 1'b1;
            done     <= 1'b0;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
          end else begin
            checksum <= checksum_sum;
            word_cnt <= word_cnt + 5'd1;
            state    <= SHIFT;
          end
        end

        CHECK: begin
          if (!load_req) begin
            state    <= IDLE;
            error    <= 1'b1;
            done     <= 1'b0;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
          end else if (checksum_sum == 8'd0) begin
            state    <= DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
          end else begin
            state <= ERROR;
            error <= 1'b1;
            busy  <= 1'b0;
          end
        end

        DONE, ERROR: begin
          if (!load_req) begin
            state    <= IDLE;
            cpu_hold <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          mem_write <= 1'b0;
          busy      <= 1'b0;
          cpu_hold  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic       clk;
  logic       rst_n;
  logic       load_req;
  logic       ser_clk;
  logic       ser_data;
  logic [3:0] mem_address;
  logic [3:0] mem_immediate;
  logic [3:0] mem_opcode;
  logic       mem_write;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       error;

  int checks = 0;
  int errors = 0;

  int         wr_count = 0;
  logic [3:0] wr_addr [0:127];
  logic [3:0] wr_imm  [0:127];
  logic [3:0] wr_op   [0:127];
  logic [7:0] exp_bytes [0:15];

  program_loader #(.SYNC_STAGES(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_req      (load_req),
    .ser_clk       (ser_clk),
    .ser_data      (ser_data),
    .mem_address   (mem_address),
    .mem_immediate (mem_immediate),
    .mem_opcode    (mem_opcode),
    .mem_write     (mem_write),
    .cpu_hold      (cpu_hold),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write log, sampled away from the active edge.
  always @(negedge clk) begin
    if (mem_write) begin
      wr_addr[wr_count & 127] <= mem_address;
      wr_imm[wr_count & 127]  <= mem_immediate;
      wr_op[wr_count & 127]   <= mem_opcode;
      wr_count <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ser_clk low 4 clk periods with data set, then high 4 periods.
  task automatic send_bit(input logic b);
    ser_data = b;
    ser_clk  = 1'b0;
    wait_clks(4);
    ser_clk = 1'b1;
    wait_clks(4);
    ser_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic check_flags(input string tag, input logic [3:0] exp_hbde);
    check(tag, {28'd0, cpu_hold, busy, done, error}, {28'd0, exp_hbde});
  endtask

  task automatic check_writes(input string tag, input int base);
    for (int i = 0; i < 16; i++) begin
      check({tag, "_addr"}, {28'd0, wr_addr[base + i]}, i);
      check({tag, "_imm"},  {28'd0, wr_imm[base + i]},  {28'd0, exp_bytes[i][7:4]});
      check({tag, "_op"},   {28'd0, wr_op[base + i]},   {28'd0, exp_bytes[i][3:0]});
    end
  endtask

  task automatic all_zero(input string tag);
    check(tag, {16'd0, mem_address, mem_immediate, mem_opcode, mem_write,
                cpu_hold, busy, done, error}, 32'd0);
  endtask

  initial begin
    int base;
    rst_n    = 1'b0;
    load_req = 1'b0;
    ser_clk  = 1'b0;
    ser_data = 1'b0;
    wait_clks(3);
    all_zero("reset_outputs");
    rst_n = 1'b1;
    wait_clks(2);

    // No session: serial activity must be ignored.
    for (int i = 0; i < 20; i++) send_bit(i[0]);
    wait_clks(4);
    check("idle_no_writes", wr_count, 0);
    all_zero("idle_flags");

    // Good image 0x00..0x0F, checksum 0x88.
    for (int i = 0; i < 16; i++) exp_bytes[i] = 8'(i);
    base = wr_count;
    load_req = 1'b1;
    wait_clks(2);
    check_flags("start_flags", 4'b1100);
    for (int i = 0; i < 16; i++) send_byte(exp_bytes[i]);
    check("good1_count_pre", wr_count - base, 16);
    check_flags("before_chk_byte", 4'b1100);
    send_byte(8'h88);
    wait_clks(4);
    check("good1_count", wr_count - base, 16);
    check_writes("good1", base);
    check_flags("good1_flags", 4'b0010);
    load_req = 1'b0;
    wait_clks(3);
    check_flags("good1_sticky", 4'b0010);

    // All 0xFF, checksum wraps to 0xF0, trailer 0x10.
    for (int i = 0; i < 16; i++) exp_bytes[i] = 8'hFF;
    base = wr_count;
    load_req = 1'b1;
    wait_clks(2);
    check_flags("restart_clears_done", 4'b1100);
    for (int i = 0; i < 16; i++) send_byte(8'hFF);
    send_byte(8'h10);
    wait_clks(4);
    check("ff_count", wr_count - base, 16);
    check_writes("ff", base);
    check_flags("ff_flags", 4'b0010);
    load_req = 1'b0;
    wait_clks(3);

    // Bad checksum.
    for (int i = 0; i < 16; i++) exp_bytes[i] = 8'(i);
    base = wr_count;
    load_req = 1'b1;
    wait_clks(2);
    for (int i = 0; i < 16; i++) send_byte(exp_bytes[i]);
    send_byte(8'h00);
    wait_clks(4);
    check("bad_count", wr_count - base, 16);
    check_flags("bad_flags", 4'b1001);
    wait_clks(10);
    check_flags("bad_hold_kept", 4'b1001);
    load_req = 1'b0;
    wait_clks(3);
    check_flags("bad_released", 4'b0001);

    // Abort after 5 bytes plus 3 bits.
    base = wr_count;
    load_req = 1'b1;
    wait_clks(2);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i));
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    load_req = 1'b0;
    wait_clks(3);
    check("abort_count", wr_count - base, 5);
    for (int i = 0; i < 5; i++) begin
      check("abort_addr", {28'd0, wr_addr[base + i]}, i);
      check("abort_op",   {28'd0, wr_op[base + i]},   i);
    end
    check_flags("abort_flags", 4'b0001);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    wait_clks(4);
    check("abort_no_more", wr_count - base, 5);

    // Reset in the middle of byte 2.
    base = wr_count;
    load_req = 1'b1;
    wait_clks(2);
    send_byte(8'hA5);
    send_byte(8'h3C);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    check("pre_rst_addr", {28'd0, mem_address}, 1);
    check("pre_rst_imm", {28'd0, mem_immediate}, 3);
    rst_n    = 1'b0;
    load_req = 1'b0;
    wait_clks(1);
    all_zero("midrst_outputs");
    wait_clks(2);
    rst_n = 1'b1;
    wait_clks(2);
    check("midrst_count", wr_count - base, 2);

    for (int i = 0; i < 16; i++) exp_bytes[i] = 8'(i);
    base = wr_count;
    load_req = 1'b1;
    wait_clks(2);
    for (int i = 0; i < 16; i++) send_byte(exp_bytes[i]);
    send_byte(8'h88);
    wait_clks(4);
    check("after_rst_count", wr_count - base, 16);
    check_writes("after_rst", base);
    check_flags("after_rst_flags", 4'b0010);
    load_req = 1'b0;
    wait_clks(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2 (min 2): flop depth of each asynchronous-input synchronizer.
REQ-002 The block SHALL have port clk  in  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port load_req  in  1  synchronous to clk; level request to run a load session.
REQ-005 The block SHALL have port ser_clk  in  1  asynchronous serial bit clock; data is sampled on its rising edge.
REQ-006 The block SHALL have port ser_data  in  1  asynchronous serial data, MSB first.
REQ-007 The block SHALL have port mem_address  out  4  program memory write address.
REQ-008 The block SHALL have port mem_immediate  out  4  write data, byte bits [7:4].
REQ-009 The block SHALL have port mem_opcode  out  4  write data, byte bits [3:0].
REQ-010 The block SHALL have port mem_write  out  1  one-cycle write strobe to program memory.
REQ-011 The block SHALL have port cpu_hold  out  1  high while the CPU must stay stalled; the external address mux selects mem_address while it is high.
REQ-012 The block SHALL have ports busy, done and error  out  1 each  session status flags.

Function
REQ-013 ser_clk and ser_data SHALL each pass through SYNC_STAGES flops; a sample event is a 0->1 transition between the last two ser_clk stages, and the bit sampled is the synchronized ser_data at that edge.
REQ-014 Source timing SHALL be ser_clk high >= SYNC_STAGES+1 clk periods and low >= SYNC_STAGES+1 clk periods, with ser_data stable across each rising edge.
REQ-015 The FSM SHALL use states IDLE, SHIFT, WRITE, CHECK, DONE and ERROR.
REQ-016 IDLE: sample events SHALL be ignored; on load_req=1 the FSM SHALL go to SHIFT and clear bit_cnt, word_cnt (0..16), the 8-bit checksum accumulator, done and error.
REQ-017 SHIFT: each sample event SHALL update shift <= {shift[6:0], bit} and increment bit_cnt; after the 8th bit the next state SHALL be WRITE if word_cnt<16, else CHECK, and bit_cnt SHALL return to 0.
REQ-018 WRITE (exactly one cycle): mem_write SHALL be 1, with mem_address=word_cnt[3:0], mem_immediate=shift[7:4] and mem_opcode=shift[3:0]; checksum <= (checksum+shift) mod 256; word_cnt SHALL increment; next state SHALL be SHIFT.
REQ-019 mem_address, mem_immediate and mem_opcode SHALL hold their last values outside WRITE; mem_write SHALL be 0 in every state except WRITE.
REQ-020 CHECK (one cycle): the 17th byte is a two's-complement checksum; if (checksum+shift) mod 256 == 0 the FSM SHALL go to DONE with done=1, otherwise to ERROR with error=1.
REQ-021 DONE and ERROR SHALL remain until load_req=0 and then go to IDLE; done and error SHALL be sticky until the next session start.
REQ-022 Abort: load_req=0 in SHIFT, WRITE or CHECK SHALL force IDLE with error=1 and done=0, with no further writes; memory words already written are not restored.
REQ-023 cpu_hold SHALL be 1 in SHIFT, WRITE, CHECK and ERROR, and 0 in IDLE and DONE.
REQ-024 busy SHALL be 1 in SHIFT, WRITE and CHECK, and 0 otherwise.
REQ-025 Sample events in WRITE, CHECK, DONE or ERROR SHALL be ignored; REQ-014 guarantees none are lost in WRITE.
REQ-026 Writes per completed session SHALL be exactly 16, to addresses 0..15 in order; address wrap SHALL NOT occur.

Reset
REQ-027 On rst_n=0 the block SHALL asynchronously enter IDLE and clear all outputs, counters, shift, checksum and synchronizer flops to 0.
REQ-028 Reset mid-session SHALL discard any partial byte; the next session SHALL restart at address 0.

Verification
REQ-029 load_req=1, bytes 0x00..0x0F then 0x88 -> 16 mem_write pulses, addr 0..15, immediate=0, opcode=addr; done=1, error=0, cpu_hold=0 after CHECK.
REQ-030 sixteen bytes 0xFF then 0x10 -> every write has immediate=0xF, opcode=0xF; checksum wraps to 0xF0; done=1.
REQ-031 bytes 0x00..0x0F then 0x00 -> 16 writes, error=1, done=0, cpu_hold=1 until load_req=0, then 0.
REQ-032 load_req dropped after 5 bytes plus 3 bits -> 5 writes (addr 0..4), error=1, IDLE, busy=0, cpu_hold=0.
REQ-033 rst_n pulse after 4 bits of byte 2 -> all outputs 0; a new full session then writes from address 0 correctly.
REQ-034 20 ser_clk pulses with load_req=0 -> no mem_write, all flags 0.
